// File: rtl/rgb2luma_if.sv
// rgb2luma_if: pixel stream in / luma stream out bundle for rgb2luma_pipe.
interface rgb2luma_if #(parameter int DW = 8, parameter int PCW = 24);
  logic           i_en, i_hav, i_vav, i_mode;
  logic [DW-1:0]  i_r, i_g, i_b;
  logic [DW-1:0]  o_y;
  logic           o_hav, o_vav, o_fs, o_mode;
  logic [PCW-1:0] o_pix_cnt;
  modport master (output i_en, i_hav, i_vav, i_mode, i_r, i_g, i_b,
                  input o_y, o_hav, o_vav, o_fs, o_mode, o_pix_cnt);
  modport slave (input i_en, i_hav, i_vav, i_mode, i_r, i_g, i_b,
                 output o_y, o_hav, o_vav, o_fs, o_mode, o_pix_cnt);
endinterface

// File: rtl/rgb2luma_pipe.sv
// rgb2luma_pipe: 3-stage RGB to luma (BT.601/BT.709) with frame-start and active-pixel count.
// Define RGB2LUMA_ROUND_EN to round half-up in the final shift instead of truncating.
module rgb2luma_pipe #(
  parameter int DW  = 8,
  parameter int PCW = 24
) (
  input logic clk,
  input logic rst,
  rgb2luma_if.slave bus
);
  localparam int PW = DW + 8;
`ifdef RGB2LUMA_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(128);
`else
  localparam logic [PW-1:0] RND = '0;
`endif
  logic [DW-1:0]  r_s1_r, r_s1_g, r_s1_b, r_y;
  logic           r_s1_hav, r_s1_vav, r_s1_mode, r_mode;
  logic [PW-1:0]  r_p_r, r_p_g, r_p_b;
  logic           r_s2_hav, r_s2_vav, r_hav, r_vav, r_fs;
  logic [PCW-1:0] r_cnt, w_cnt;
  logic           w_act, w_vrise, w_mode, w_fs, w_px;
  logic [7:0]     w_cr, w_cg, w_cb;
  logic [DW-1:0]  w_y;
  always_comb begin
    w_act   = bus.i_hav & bus.i_vav;
    w_vrise = bus.i_vav & ~r_s1_vav;
    // the first pixel of a new frame already uses the freshly loaded mode
    w_mode  = w_vrise ? bus.i_mode : r_mode;
    w_cr    = r_s1_mode ? 8'd54  : 8'd77;
    w_cg    = r_s1_mode ? 8'd183 : 8'd150;
    w_cb    = r_s1_mode ? 8'd19  : 8'd29;
    w_y     = DW'((r_p_r + r_p_g + r_p_b + RND) >> 8);
    w_fs    = r_s2_vav & ~r_vav;
    w_px    = r_s2_hav & r_s2_vav;
    w_cnt   = w_fs ? PCW'(w_px) : (w_px && r_cnt != '1) ? r_cnt + PCW'(1) : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_r    <= '0;
      r_s1_g    <= '0;
      r_s1_b    <= '0;
      r_s1_hav  <= 1'b0;
      r_s1_vav  <= 1'b0;
      r_s1_mode <= 1'b0;
      r_mode    <= 1'b0;
      r_p_r     <= '0;
      r_p_g     <= '0;
      r_p_b     <= '0;
      r_s2_hav  <= 1'b0;
      r_s2_vav  <= 1'b0;
      r_y       <= '0;
      r_hav     <= 1'b0;
      r_vav     <= 1'b0;
      r_fs      <= 1'b0;
      r_cnt     <= '0;
    end else if (bus.i_en) begin
      r_s1_r    <= w_act ? bus.i_r : '0;
      r_s1_g    <= w_act ? bus.i_g : '0;
      r_s1_b    <= w_act ? bus.i_b : '0;
      r_s1_hav  <= bus.i_hav;
      r_s1_vav  <= bus.i_vav;
      r_s1_mode <= w_mode;
      r_mode    <= w_mode;
      r_p_r     <= PW'(r_s1_r) * PW'(w_cr);
      r_p_g     <= PW'(r_s1_g) * PW'(w_cg);
      r_p_b     <= PW'(r_s1_b) * PW'(w_cb);
      r_s2_hav  <= r_s1_hav;
      r_s2_vav  <= r_s1_vav;
      r_y       <= w_y;
      r_hav     <= r_s2_hav;
      r_vav     <= r_s2_vav;
      r_fs      <= w_fs;
      r_cnt     <= w_cnt;
    end
  end
  assign bus.o_y       = r_y;
  assign bus.o_hav     = r_hav;
  assign bus.o_vav     = r_vav;
  assign bus.o_fs      = r_fs & bus.i_en;
  assign bus.o_pix_cnt = r_cnt;
  assign bus.o_mode    = r_mode;
endmodule

// File: tb/tb_rgb2luma_pipe.sv
// tb_rgb2luma_pipe: directed checks of luma math, blanking, stall, mode switch, reset and counter saturation.
module tb_rgb2luma_pipe;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
`ifdef RGB2LUMA_ROUND_EN
  localparam int RED601 = 77;
  localparam int RED709 = 54;
`else
  localparam int RED601 = 76;
  localparam int RED709 = 53;
`endif
  rgb2luma_if #(.DW(8), .PCW(24)) a();
  rgb2luma_if #(.DW(8), .PCW(2))  b();
  rgb2luma_pipe #(.DW(8), .PCW(24)) dut  (.clk(clk), .rst(rst), .bus(a));
  rgb2luma_pipe #(.DW(8), .PCW(2))  dut2 (.clk(clk), .rst(rst), .bus(b));
  assign b.i_en   = a.i_en;
  assign b.i_hav  = a.i_hav;
  assign b.i_vav  = a.i_vav;
  assign b.i_mode = a.i_mode;
  assign b.i_r    = a.i_r;
  assign b.i_g    = a.i_g;
  assign b.i_b    = a.i_b;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] bl);
    a.i_r = r;
    a.i_g = g;
    a.i_b = bl;
  endtask
  task automatic pix(input logic h, input logic [7:0] r, input logic [7:0] g, input logic [7:0] bl);
    a.i_hav = h;
    a.i_vav = 1'b1;
    rgb(r, g, bl);
    tick();
    a.i_hav = 1'b0;
    rgb(8'd0, 8'd0, 8'd0);
    tick();
    tick();
  endtask
  int   exp_y [10] = '{0, 0, 10, 10, 10, 20, 30, 40, 50, 0};
  int   exp_c [10] = '{0, 0, 1, 1, 1, 2, 3, 4, 5, 5};
  int   val   [10] = '{10, 20, 30, 99, 99, 40, 50, 0, 0, 0};
  logic en_s  [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  logic hav_s [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  initial begin
    rst = 1'b1;
    a.i_en = 1'b0; a.i_hav = 1'b0; a.i_vav = 1'b0; a.i_mode = 1'b0;
    rgb(8'd0, 8'd0, 8'd0);
    tick();
    tick();
    chk("rst_y", 32'(a.o_y), 0);
    chk("rst_hav", 32'(a.o_hav), 0);
    chk("rst_vav", 32'(a.o_vav), 0);
    chk("rst_fs", 32'(a.o_fs), 0);
    chk("rst_cnt", 32'(a.o_pix_cnt), 0);
    chk("rst_mode", 32'(a.o_mode), 0);
    rst = 1'b0;
    a.i_en = 1'b1;
    pix(1'b1, 8'd255, 8'd255, 8'd255);
    chk("white601_y", 32'(a.o_y), 255);
    chk("white601_hav", 32'(a.o_hav), 1);
    chk("white601_fs", 32'(a.o_fs), 1);
    chk("white601_cnt", 32'(a.o_pix_cnt), 1);
    pix(1'b1, 8'd255, 8'd0, 8'd0);
    chk("red601_y", 32'(a.o_y), 32'(RED601));
    chk("red601_fs", 32'(a.o_fs), 0);
    chk("red601_cnt", 32'(a.o_pix_cnt), 2);
    a.i_mode = 1'b1;
    pix(1'b1, 8'd255, 8'd0, 8'd0);
    chk("midswitch_y", 32'(a.o_y), 32'(RED601));
    chk("midswitch_mode", 32'(a.o_mode), 0);
    chk("midswitch_cnt", 32'(a.o_pix_cnt), 3);
    pix(1'b0, 8'd200, 8'd200, 8'd200);
    chk("blank_y", 32'(a.o_y), 0);
    chk("blank_hav", 32'(a.o_hav), 0);
    chk("blank_vav", 32'(a.o_vav), 1);
    chk("blank_cnt", 32'(a.o_pix_cnt), 3);
    a.i_vav = 1'b0;
    repeat (4) tick();
    chk("vblank_vav", 32'(a.o_vav), 0);
    pix(1'b1, 8'd0, 8'd255, 8'd0);
    chk("green709_y", 32'(a.o_y), 182);
    chk("green709_fs", 32'(a.o_fs), 1);
    chk("green709_cnt", 32'(a.o_pix_cnt), 1);
    chk("green709_mode", 32'(a.o_mode), 1);
    pix(1'b1, 8'd255, 8'd0, 8'd0);
    chk("red709_y", 32'(a.o_y), 32'(RED709));
    a.i_vav = 1'b0;
    a.i_hav = 1'b0;
    repeat (4) tick();
    a.i_vav = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a.i_en  = en_s[i];
      a.i_hav = hav_s[i];
      rgb(8'(val[i]), 8'(val[i]), 8'(val[i]));
      tick();
      if (i >= 2) begin
        chk($sformatf("stall_y%0d", i), 32'(a.o_y), 32'(exp_y[i]));
        chk($sformatf("stall_cnt%0d", i), 32'(a.o_pix_cnt), 32'(exp_c[i]));
      end
      if (i == 2) chk("stall_fs2", 32'(a.o_fs), 1);
      if (i == 3) chk("stall_fs3", 32'(a.o_fs), 0);
    end
    chk("sat_cnt", 32'(b.o_pix_cnt), 3);
    a.i_hav = 1'b1;
    rgb(8'd255, 8'd255, 8'd255);
    tick();
    tick();
    rst = 1'b1;
    a.i_en = 1'b0;
    tick();
    chk("midrst_y", 32'(a.o_y), 0);
    chk("midrst_hav", 32'(a.o_hav), 0);
    chk("midrst_vav", 32'(a.o_vav), 0);
    chk("midrst_fs", 32'(a.o_fs), 0);
    chk("midrst_cnt", 32'(a.o_pix_cnt), 0);
    chk("midrst_mode", 32'(a.o_mode), 0);
    rst = 1'b0;
    a.i_en = 1'b1;
    tick();
    tick();
    chk("postrst_flush_y", 32'(a.o_y), 0);
    chk("postrst_flush_vav", 32'(a.o_vav), 0);
    tick();
    chk("postrst_y", 32'(a.o_y), 255);
    chk("postrst_fs", 32'(a.o_fs), 1);
    chk("postrst_cnt", 32'(a.o_pix_cnt), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
